// File: rtl/fir_serial_seq_ctrl.sv
// Sequencer for a serial-MAC FIR: one TAPS-long enable burst per sample, priming drop,
// decimation and a 1-entry output buffer. Optional stall mode: FIR_SEQ_BACKPRESSURE_EN.
module fir_serial_seq_ctrl #(
  parameter int unsigned TAPS  = 28,
  parameter int unsigned DECIM = 1,
  parameter int unsigned PRIME = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,      // active-high synchronous reset despite the name
  input  logic        in_valid_i,
  input  logic [23:0] in_data_i,
  output logic        in_ready_o,
  output logic        fir_en_o,
  output logic [23:0] fir_din_o,
  input  logic        fir_phase_i,
  input  logic [23:0] fir_dout_i,
  output logic        out_valid_o,
  output logic [23:0] out_data_o,
  input  logic        out_ready_i,
  output logic        overrun_o,
  output logic        sync_err_o
);

  typedef enum logic [1:0] {StIdle, StBurst, StCapt} state_e;

  localparam logic [4:0] BcntLast = 5'(TAPS - 1);
  localparam logic [8:0] DecLast  = 9'(DECIM - 1);
  localparam logic [1:0] PrimeNum = 2'(PRIME);

  state_e      st_q, st_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [1:0]  prime_cnt_q, prime_cnt_d;
  logic [8:0]  dec_cnt_q, dec_cnt_d;
  logic [23:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        in_ready_q, in_ready_d;
  logic        fir_en_q, fir_en_d;
  logic        out_valid_q, out_valid_d;
  logic [23:0] out_data_q, out_data_d;
  logic        overrun_q, overrun_d;
  logic        sync_err_q, sync_err_d;
  logic        out_free, fwd, can_start, capt_go;

  always_comb begin
    out_free = ~out_valid_q | out_ready_i;
    fwd      = (st_q == StCapt) && (prime_cnt_q >= PrimeNum) && (dec_cnt_q == '0);
`ifdef FIR_SEQ_BACKPRESSURE_EN
    can_start = out_free;
    capt_go   = ~fwd | out_free;  // hold in CAPT rather than lose a result
`else
    can_start = 1'b1;
    capt_go   = 1'b1;
`endif

    st_d        = st_q;
    bcnt_d      = bcnt_q;
    prime_cnt_d = prime_cnt_q;
    dec_cnt_d   = dec_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    overrun_d   = overrun_q;
    sync_err_d  = sync_err_q;

    unique case (st_q)
      StIdle: begin
        if (hold_full_q && can_start) begin
          st_d   = StBurst;
          bcnt_d = '0;
        end
      end
      StBurst: begin
        if ((bcnt_q == '0) != fir_phase_i) sync_err_d = 1'b1;
        if (bcnt_q == '0) hold_full_d = 1'b0;
        if (bcnt_q == BcntLast) st_d = StCapt;
        else bcnt_d = bcnt_q + 5'd1;
      end
      StCapt: begin
        if (capt_go) begin
          if (prime_cnt_q < PrimeNum) prime_cnt_d = prime_cnt_q + 2'd1;
          else dec_cnt_d = (dec_cnt_q == DecLast) ? '0 : dec_cnt_q + 9'd1;
          st_d   = (hold_full_q && can_start) ? StBurst : StIdle;
          bcnt_d = '0;
        end
      end
      default: st_d = StIdle;
    endcase

    // Set after the burst clear so a same-edge accept keeps the hold register full
    if (in_valid_i && in_ready_q) begin
      hold_d      = in_data_i;
      hold_full_d = 1'b1;
    end

    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (fwd && capt_go) begin
      if (out_free) begin
        out_valid_d = 1'b1;
        out_data_d  = fir_dout_i;
      end else begin
        overrun_d = 1'b1;
      end
    end

    in_ready_d = ~hold_full_d;
    fir_en_d   = (st_d == StBurst);
  end

  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      st_q        <= StIdle;
      bcnt_q      <= '0;
      prime_cnt_q <= '0;
      dec_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      fir_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      st_q        <= st_d;
      bcnt_q      <= bcnt_d;
      prime_cnt_q <= prime_cnt_d;
      dec_cnt_q   <= dec_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      in_ready_q  <= in_ready_d;
      fir_en_q    <= fir_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign fir_en_o    = fir_en_q;
  assign fir_din_o   = hold_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign overrun_o   = overrun_q;
  assign sync_err_o  = sync_err_q;

endmodule

// File: tb/tb_fir_serial_seq_ctrl.sv
// Bench for fir_serial_seq_ctrl: behavioural FIR environment, impulse table, and a
// sample-level scoreboard for a DECIM=1 and a DECIM=9 instance fed identical stimulus.
module tb_fir_serial_seq_ctrl;
  localparam int Taps  = 28;
  localparam int Prime = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready, force_ph;
  logic [23:0] in_data;
  logic        in_ready, fir_en, fir_phase, out_valid, overrun, sync_err;
  logic [23:0] fir_din, fir_dout, out_data;
  logic        in_ready9, fir_en9, out_valid9, overrun9, sync_err9;
  logic [23:0] fir_din9, out_data9;

  fir_serial_seq_ctrl #(.TAPS(28), .DECIM(1), .PRIME(2)) dut (
    .clk_i(clk), .rst_n_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .fir_en_o(fir_en), .fir_din_o(fir_din), .fir_phase_i(fir_phase),
    .fir_dout_i(fir_dout), .out_valid_o(out_valid), .out_data_o(out_data),
    .out_ready_i(out_ready), .overrun_o(overrun), .sync_err_o(sync_err)
  );

  fir_serial_seq_ctrl #(.TAPS(28), .DECIM(9), .PRIME(2)) dut9 (
    .clk_i(clk), .rst_n_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready9), .fir_en_o(fir_en9), .fir_din_o(fir_din9), .fir_phase_i(fir_phase),
    .fir_dout_i(fir_dout), .out_valid_o(out_valid9), .out_data_o(out_data9),
    .out_ready_i(out_ready), .overrun_o(overrun9), .sync_err_o(sync_err9)
  );

  int coef [Taps] = '{50, 97, -31, -392, -610, 120, 1800, 3900, 5200, 4100, 900, -2100,
                      -1500, 700, 700, -1500, -2100, 900, 4100, 5200, 3900, 1800, 120, -610,
                      -392, -31, 97, 50};

  // FIR environment: loads on phase 27, output lags the loaded stream by two bursts
  logic [23:0] hist [Taps];
  logic [23:0] ypipe, fdout;
  int          ph;

  function automatic logic [23:0] hist_y();
    longint acc = 0;
    for (int i = 0; i < Taps; i++) acc += longint'(coef[i]) * longint'($signed(hist[i]));
    acc = acc >>> 17;
    return 24'(acc);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph    <= Taps - 1;
      ypipe <= '0;
      fdout <= '0;
      for (int i = 0; i < Taps; i++) hist[i] <= '0;
    end else if (fir_en) begin
      if (ph == Taps - 1) begin
        fdout   <= ypipe;
        ypipe   <= hist_y();
        for (int i = Taps - 1; i > 0; i--) hist[i] <= hist[i-1];
        hist[0] <= fir_din;
        ph      <= 0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  assign fir_phase = (ph == Taps - 1) || force_ph;
  assign fir_dout  = fdout;

  // Reference model and bookkeeping
  logic [23:0] xs [$];
  logic [23:0] exp1 [$], exp9 [$], got1 [$], got9 [$];
  int errors = 0, checks = 0;
  int en_cnt, first_en, last_en, cyc_n = 0;
  bit acc, en_now, sb_on, rand_rdy;

  function automatic logic [23:0] ref_y(int m);
    longint a = 0;
    for (int i = 0; i < Taps; i++)
      if (m - i >= 0) a += longint'(coef[i]) * longint'($signed(xs[m-i]));
    a = a >>> 17;
    return 24'(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic sb(input string name, input logic [23:0] act, inout logic [23:0] q [$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got result %0h, required no result", name, act);
    end else begin
      chk(name, 32'(act), 32'(q.pop_front()));
    end
  endtask

  task automatic mon();
    acc    = in_valid && in_ready;
    en_now = fir_en;
    if (acc) begin
      xs.push_back(in_data);
      if (xs.size() > Prime) begin
        int m = xs.size() - 1 - Prime;
        exp1.push_back(ref_y(m));
        if (m % 9 == 0) exp9.push_back(ref_y(m));
      end
    end
    if (fir_en) begin
      en_cnt++;
      if (first_en < 0) first_en = cyc_n;
      last_en = cyc_n;
    end
    if (out_valid && out_ready) begin
      got1.push_back(out_data);
      if (sb_on) sb("sb_decim1", out_data, exp1);
    end
    if (out_valid9 && out_ready) begin
      got9.push_back(out_data9);
      if (sb_on) sb("sb_decim9", out_data9, exp9);
    end
    cyc_n++;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 4) != 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (n) cyc();
    rst = 1'b0;
    xs.delete(); exp1.delete(); exp9.delete(); got1.delete(); got9.delete();
    en_cnt = 0;
    first_en = -1;
    last_en = -1;
  endtask

  task automatic send(input logic [23:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin cyc(); n++; end while (!acc && n < 400);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %0h not accepted, required within 400 cycles", d);
    end
  endtask

  task automatic wait_en();
    int n = 0;
    do begin cyc(); n++; end while (!en_now && n < 200);
    if (!en_now) begin
      checks++;
      errors++;
      $display("FAIL wait_fir_en: fir_en stayed 0, required a burst within 200 cycles");
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_fir_en"}, 32'(fir_en), 32'd0);
    chk({tag, "_fir_din"}, 32'(fir_din), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'd0);
  endtask

  typedef struct {
    logic [23:0] din;
    logic [23:0] dout;
  } vec_t;
  vec_t imp_tab [32];

  initial begin
    logic [23:0] last_d;
    int run;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; force_ph = 1'b0;
    sb_on = 1'b1; rand_rdy = 1'b0;

    // Impulse table: results lag inputs by PRIME samples
    for (int k = 0; k < 32; k++) begin
      imp_tab[k].din  = (k == 0) ? 24'h020000 : 24'h000000;
      imp_tab[k].dout = (k >= 2 && k - 2 < Taps) ? 24'(coef[k-2]) : 24'h000000;
    end
    imp_tab[2].dout = 24'h000032;
    imp_tab[3].dout = 24'h000061;
    imp_tab[4].dout = 24'hFFFFE1;
    imp_tab[5].dout = 24'hFFFE78;

    do_reset(2);
    chk_reset("reset");

    // T1 impulse
    for (int k = 0; k < 32; k++) send(imp_tab[k].din);
    in_valid = 1'b0;
    repeat (80) cyc();
    chk("t1_count", got1.size(), 30);
    for (int k = 2; k < 32; k++)
      chk($sformatf("t1_out%0d", k - 2), 32'((k - 2 < got1.size()) ? got1[k-2] : 24'hxxxxxx),
          32'(imp_tab[k].dout));

    // T2 throughput with in_valid held high
    do_reset(1);
    for (int k = 0; k < 100; k++) send(24'($urandom));
    in_valid = 1'b0;
    repeat (80) cyc();
    chk("t2_en_cycles", en_cnt, 2800);
    chk("t2_en_span", last_en - first_en + 1, 2899);
    chk("t2_results", got1.size(), 98);
    chk("t2_results_d9", got9.size(), 11);
    chk("t2_overrun", overrun, 0);
    chk("t2_sync_err", sync_err, 0);

    // T3 decimation with constant input
    do_reset(1);
    for (int k = 0; k < 90; k++) send(24'h020000);
    in_valid = 1'b0;
    repeat (80) cyc();
    chk("t3_results_d9", got9.size(), 10);
    chk("t3_results", got1.size(), 88);

    // Random gaps and random downstream readiness
    do_reset(1);
    rand_rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) cyc();
      send(24'($urandom));
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (80) cyc();
    chk("rnd_left", exp1.size(), 0);
    chk("rnd_left_d9", exp9.size(), 0);
    chk("rnd_overrun", overrun, 0);

    // T4 overrun: downstream never ready
    do_reset(1);
    sb_on = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(24'($urandom));
      in_valid = 1'b0;
    end
    run = 0;
    while (!out_valid && run < 400) begin cyc(); run++; end
    chk("t4_first_valid", out_valid, 1);
    chk("t4_no_early_overrun", overrun, 0);
    repeat (150) cyc();
    chk("t4_out_valid", out_valid, 1);
    chk("t4_out_data", 32'(out_data), 32'(ref_y(0)));
`ifdef FIR_SEQ_BACKPRESSURE_EN
    chk("t4_overrun", overrun, 0);
    chk("t4_stalled_en", fir_en, 0);
    chk("t4_stalled_ready", in_ready, 0);
    out_ready = 1'b1;
    repeat (100) cyc();
`else
    chk("t4_overrun", overrun, 1);
`endif

    // T5 reset in the middle of a burst
    send(24'h123456);
    in_valid = 1'b0;
    wait_en();
    repeat (12) cyc();
    do_reset(1);
    chk_reset("t5");
    out_ready = 1'b1;
    send(24'h0ABCDE);
    in_valid = 1'b0;
    wait_en();
    run = 1;
    for (int i = 0; i < 40 && en_now; i++) begin
      cyc();
      if (en_now) run++;
    end
    chk("t5_burst_len", run, 28);
    chk("t5_sync_err", sync_err, 0);

    // T6 phase fault at bcnt 5
    do_reset(1);
    sb_on = 1'b1;
    send(24'($urandom));
    in_valid = 1'b0;
    wait_en();
    repeat (4) cyc();
    chk("t6_before", sync_err, 0);
    force_ph = 1'b1;
    cyc();
    force_ph = 1'b0;
    chk("t6_set", sync_err, 1);
    for (int k = 0; k < 6; k++) begin
      last_d = 24'($urandom);
      send(last_d);
    end
    in_valid = 1'b0;
    repeat (80) cyc();
    chk("t6_sticky", sync_err, 1);
    chk("t6_results", got1.size(), 5);
    chk("t6_left", exp1.size(), 0);

    // Quiescent state of both instances
    chk("end_in_ready", in_ready, 1);
    chk("end_fir_en", fir_en, 0);
    chk("end_fir_din", 32'(fir_din), 32'(last_d));
    chk("end_in_ready_d9", in_ready9, 1);
    chk("end_fir_en_d9", fir_en9, 0);
    chk("end_fir_din_d9", 32'(fir_din9), 32'(last_d));
    chk("end_overrun_d9", overrun9, 0);
    chk("end_sync_err_d9", sync_err9, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
